// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the 3x3 convolution sequencer.
package conv_pkg;
  localparam int N_TAPS = 9;
  localparam int ACC_W  = 20;
  localparam int BYTE_W = 8;
  localparam int SHIFT  = 4;
  localparam int IDX_W  = 4;

  localparam logic [BYTE_W-1:0] SAT_MAX  = 8'd255;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_TAPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_P,
    MAC,
    POST,
    OUT
  } state_e;
endpackage

// File: rtl/conv_mac_step.sv
// One multiply-accumulate step: signed weight times unsigned pixel, added to the running sum.
module conv_mac_step
  import conv_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic        [BYTE_W-1:0] w_i,
  input  logic        [BYTE_W-1:0] p_i,
  output logic signed [ACC_W-1:0]  acc_o
);
  logic signed [BYTE_W:0]   p_ext;
  logic signed [2*BYTE_W:0] prod;

  // A zero-extended pixel keeps the whole product signed, so 255 is never read as -1.
  assign p_ext = {1'b0, p_i};
  assign prod  = $signed(w_i) * p_ext;
  assign acc_o = acc_i + {{(ACC_W-2*BYTE_W-1){prod[2*BYTE_W]}}, prod};
endmodule

// File: rtl/conv3x3_seq_ctrl.sv
// Byte-stream sequencer for a 3x3 convolution: loads weights and pixels, runs 9 MAC
// cycles on one shared multiplier, then applies ReLU, shift and saturation.
module conv3x3_seq_ctrl
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_kind,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              sat,
  output logic              weights_ok,
  output logic              err,
  output logic              busy
);
  state_e                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic [BYTE_W-1:0]        w_q [N_TAPS];
  logic [BYTE_W-1:0]        p_q [N_TAPS];
  logic                     in_ready_q, out_valid_q, sat_q, weights_ok_q, err_q, busy_q;
  logic [BYTE_W-1:0]        out_data_q;

  logic [ACC_W-1:0]         shifted_d;
  logic                     sat_d;
  logic [BYTE_W-1:0]        clip_d;
  logic                     in_xfer;

  assign in_xfer = in_valid & in_ready_q;

  conv_mac_step u_mac (
    .acc_i (acc_q),
    .w_i   (w_q[idx_q]),
    .p_i   (p_q[idx_q]),
    .acc_o (acc_d)
  );

  // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    shifted_d = acc_q[ACC_W-1] ? '0 : acc_q >>> SHIFT;
    sat_d     = shifted_d > {{(ACC_W-BYTE_W){1'b0}}, SAT_MAX};
    clip_d    = sat_d ? SAT_MAX : shifted_d[BYTE_W-1:0];
  end

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sat_q        <= 1'b0;
      weights_ok_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      // NOTE: the tap files are cleared too; a reset mid-MAC must leave no stale operands.
      for (int i = 0; i < N_TAPS; i++) begin
        w_q[i] <= '0;
        p_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: if (in_xfer) begin
          if (in_kind) begin
            w_q[0]  <= in_data;
            state_q <= LOAD_W;
          end else begin
            p_q[0]  <= in_data;
            state_q <= LOAD_P;
          end
          idx_q  <= IDX_W'(1);
          busy_q <= 1'b1;
        end
        LOAD_W: if (in_xfer) begin
          w_q[idx_q] <= in_data;
          if (idx_q == LAST_IDX) begin
            weights_ok_q <= 1'b1;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        LOAD_P: if (in_xfer) begin
          p_q[idx_q] <= in_data;
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            if (weights_ok_q) begin
              acc_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= MAC;
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= POST;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        POST: begin
          out_data_q  <= clip_d;
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign sat        = sat_q;
  assign weights_ok = weights_ok_q;
  assign err        = err_q;
  assign busy       = busy_q;
endmodule
